fu_wb_arbiter: RTL and testbench

- Shares one writeback/broadcast port among NUM_FU functional units.
- Sits between the FU result outputs (fu_out_* fields of each FU's ctrl-side interface) and the ROB/PRF writeback bus.
- Each FU result is buffered in a small per-FU queue. A round-robin arbiter drains one result per cycle when the consumer accepts it.
- Raises per-FU hold so the issue logic stops dispatching to FUs whose queue is nearly full.

---
 rtl/fu_pkg.sv | 20 ++
 rtl/fu_wb_queue.sv | 50 +++++
 rtl/fu_wb_arbiter.sv | 128 ++++++++++++
 tb/tb_fu_wb_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_pkg.sv
// Shared types and default widths for the FU writeback path.
// Default FU result layout matches the FU ctrl-side interface.
package fu_pkg;

    localparam int NUM_FU_DEF       = 4;
    localparam int INST_ID_BITS_DEF = 6;
    localparam int PRN_BITS_DEF     = 6;
    localparam int MAX_OPERANDS_DEF = 3;
    localparam int QUEUE_DEPTH_DEF  = 2;
    localparam int DATA_BITS        = 64;
    localparam int FU_IDX_BITS      = $clog2(NUM_FU_DEF);

    typedef struct packed {
        logic [INST_ID_BITS_DEF-1:0]                        inst_id;
        logic [MAX_OPERANDS_DEF-1:0][PRN_BITS_DEF-1:0]      prn;
        logic [MAX_OPERANDS_DEF-1:0][DATA_BITS-1:0]         data;
        logic [MAX_OPERANDS_DEF-1:0]                        data_valid;
    } fu_result_t;

endpackage

// File: rtl/fu_wb_queue.sv
// Single-FU result FIFO; pointers carry an extra wrap bit so count spans 0..DEPTH.
// Push while full is accepted only when a pop happens in the same cycle.
module fu_wb_queue
    import fu_pkg::*;
#(
    parameter type T     = fu_result_t,
    parameter int  DEPTH = QUEUE_DEPTH_DEF,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  T              push_data,
    input  logic          pop,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;
    T              mem [DEPTH];

    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is qualified by the pointers, so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fu_wb_arbiter.sv
// Round-robin share of one writeback port among NUM_FU functional units.
// Optional FU_WB_ARB_PERF_EN adds per-FU saturating stall counters.
module fu_wb_arbiter
    import fu_pkg::*;
#(
    parameter int NUM_FU       = NUM_FU_DEF,
    parameter int INST_ID_BITS = INST_ID_BITS_DEF,
    parameter int PRN_BITS     = PRN_BITS_DEF,
    parameter int MAX_OPERANDS = MAX_OPERANDS_DEF,
    parameter int QUEUE_DEPTH  = QUEUE_DEPTH_DEF
) (
    input  logic                                               clk,
    input  logic                                               rst,
    input  logic [NUM_FU-1:0]                                  fu_out_valid,
    input  logic [NUM_FU-1:0][INST_ID_BITS-1:0]                fu_out_inst_id,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  fu_out_prn,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][63:0]          fu_out_data,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0]                fu_out_data_valid,
    output logic [NUM_FU-1:0]                                  fu_hold,
    input  logic                                               wb_ready,
    output logic                                               wb_valid,
    output logic [$clog2(NUM_FU)-1:0]                          wb_fu_idx,
    output logic [INST_ID_BITS-1:0]                            wb_inst_id,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              wb_prn,
    output logic [MAX_OPERANDS-1:0][63:0]                      wb_data,
    output logic [MAX_OPERANDS-1:0]                            wb_data_valid,
    output logic                                               overflow_err
`ifdef FU_WB_ARB_PERF_EN
    ,
    output logic [NUM_FU-1:0][31:0]                            perf_stall_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_FU);
    localparam int CW    = $clog2(QUEUE_DEPTH) + 1;

    typedef struct packed {
        logic [INST_ID_BITS-1:0]                   inst_id;
        logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     prn;
        logic [MAX_OPERANDS-1:0][63:0]             data;
        logic [MAX_OPERANDS-1:0]                   data_valid;
    } res_t;

    res_t              push_data [NUM_FU];
    res_t              head      [NUM_FU];
    logic [CW-1:0]     count     [NUM_FU];
    logic [NUM_FU-1:0] full;
    logic [NUM_FU-1:0] empty;
    logic [NUM_FU-1:0] pop;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant;
    logic              fire;
    res_t              sel;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_q
        assign push_data[i] = '{inst_id:    fu_out_inst_id[i],
                                prn:        fu_out_prn[i],
                                data:       fu_out_data[i],
                                data_valid: fu_out_data_valid[i]};
        assign pop[i]       = fire && (grant == IDX_W'(i));
        // Hold one slot back for a result already in the FU pipeline.
        assign fu_hold[i]   = (count[i] >= CW'(QUEUE_DEPTH - 1));

        fu_wb_queue #(
            .T     (res_t),
            .DEPTH (QUEUE_DEPTH)
        ) u_q (
            .clk       (clk),
            .rst       (rst),
            .push      (fu_out_valid[i]),
            .push_data (push_data[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (count[i]),
            .full      (full[i]),
            .empty     (empty[i])
        );
    end

    // Grant depends only on registered queue state and rr_ptr, never on this cycle's pushes.
    always_comb begin
        int  idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_FU;
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = IDX_W'(idx);
            end
        end
    end

    assign wb_valid      = ~&empty;
    assign fire          = wb_valid & wb_ready;
    assign sel           = head[grant];
    assign wb_fu_idx     = wb_valid ? grant          : '0;
    assign wb_inst_id    = wb_valid ? sel.inst_id    : '0;
    assign wb_prn        = wb_valid ? sel.prn        : '0;
    assign wb_data       = wb_valid ? sel.data       : '0;
    assign wb_data_valid = wb_valid ? sel.data_valid : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr       <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (fire) rr_ptr <= (grant == IDX_W'(NUM_FU - 1)) ? '0 : grant + 1'b1;
            if (|(fu_out_valid & full & ~pop)) overflow_err <= 1'b1;
        end
    end

`ifdef FU_WB_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!empty[i] && (grant != IDX_W'(i) || !wb_ready) && perf_stall_cnt[i] != '1)
                    perf_stall_cnt[i] <= perf_stall_cnt[i] + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Bench for fu_wb_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_fu_wb_arbiter;
    import fu_pkg::*;

    localparam int N  = 4;
    localparam int IB = 6;
    localparam int PB = 6;
    localparam int MO = 3;
    localparam int QD = 2;
    localparam int IW = FU_IDX_BITS;

    logic                           clk;
    logic                           rst;
    logic [N-1:0]                   fu_out_valid;
    logic [N-1:0][IB-1:0]           fu_out_inst_id;
    logic [N-1:0][MO-1:0][PB-1:0]   fu_out_prn;
    logic [N-1:0][MO-1:0][63:0]     fu_out_data;
    logic [N-1:0][MO-1:0]           fu_out_data_valid;
    logic [N-1:0]                   fu_hold;
    logic                           wb_ready;
    logic                           wb_valid;
    logic [IW-1:0]                  wb_fu_idx;
    logic [IB-1:0]                  wb_inst_id;
    logic [MO-1:0][PB-1:0]          wb_prn;
    logic [MO-1:0][63:0]            wb_data;
    logic [MO-1:0]                  wb_data_valid;
    logic                           overflow_err;
`ifdef FU_WB_ARB_PERF_EN
    logic [N-1:0][31:0]             perf_stall_cnt;
`endif

    fu_wb_arbiter #(
        .NUM_FU(N), .INST_ID_BITS(IB), .PRN_BITS(PB), .MAX_OPERANDS(MO), .QUEUE_DEPTH(QD)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .fu_out_valid      (fu_out_valid),
        .fu_out_inst_id    (fu_out_inst_id),
        .fu_out_prn        (fu_out_prn),
        .fu_out_data       (fu_out_data),
        .fu_out_data_valid (fu_out_data_valid),
        .fu_hold           (fu_hold),
        .wb_ready          (wb_ready),
        .wb_valid          (wb_valid),
        .wb_fu_idx         (wb_fu_idx),
        .wb_inst_id        (wb_inst_id),
        .wb_prn            (wb_prn),
        .wb_data           (wb_data),
        .wb_data_valid     (wb_data_valid),
        .overflow_err      (overflow_err)
`ifdef FU_WB_ARB_PERF_EN
        ,
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Reference model: one FIFO per FU, a round-robin start index and a sticky drop flag.
    fu_result_t mq [N][$];
    int         rr   = 0;
    bit         movf = 0;

    function automatic fu_result_t cur_input(input int i);
        fu_result_t r;
        r.inst_id    = fu_out_inst_id[i];
        r.prn        = fu_out_prn[i];
        r.data       = fu_out_data[i];
        r.data_valid = fu_out_data_valid[i];
        return r;
    endfunction

    always @(negedge clk) begin
        int         g;
        fu_result_t e;
        if (!rst) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            rr   = 0;
            movf = 0;
        end
        g = -1;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && mq[(rr + k) % N].size() > 0) g = (rr + k) % N;
        end
        check("wb_valid", 64'(wb_valid), 64'(g >= 0));
        if (g >= 0) e = mq[g][0];
        else        e = '0;
        check("wb_fu_idx", 64'(wb_fu_idx), (g >= 0) ? 64'(g) : 64'd0);
        check("wb_inst_id", 64'(wb_inst_id), 64'(e.inst_id));
        check("wb_prn", 64'(wb_prn), 64'(e.prn));
        for (int s = 0; s < MO; s++) check("wb_data", wb_data[s], e.data[s]);
        check("wb_data_valid", 64'(wb_data_valid), 64'(e.data_valid));
        for (int i = 0; i < N; i++) check("fu_hold", 64'(fu_hold[i]), 64'(mq[i].size() >= QD - 1));
        check("overflow_err", 64'(overflow_err), 64'(movf));
        if (rst) begin
            if (g >= 0 && wb_ready) begin
                void'(mq[g].pop_front());
                rr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (fu_out_valid[i]) begin
                    if (mq[i].size() < QD) mq[i].push_back(cur_input(i));
                    else                   movf = 1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_fields(input int i);
        fu_out_inst_id[i]    = IB'($urandom);
        fu_out_data_valid[i] = MO'($urandom);
        for (int s = 0; s < MO; s++) begin
            fu_out_prn[i][s]  = PB'($urandom);
            fu_out_data[i][s] = {$urandom, $urandom};
        end
    endtask

    task automatic drive(input logic [N-1:0] mask, input logic rdy);
        for (int i = 0; i < N; i++) if (mask[i]) rand_fields(i);
        fu_out_valid = mask;
        wb_ready     = rdy;
        step();
        fu_out_valid = '0;
    endtask

    task automatic idle(input int n, input logic rdy);
        wb_ready = rdy;
        for (int c = 0; c < n; c++) step();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        rst               = 1'b0;
        fu_out_valid      = '0;
        fu_out_inst_id    = '0;
        fu_out_prn        = '0;
        fu_out_data       = '0;
        fu_out_data_valid = '0;
        wb_ready          = 1'b0;
        step();
        step();
        rst = 1'b1;
        idle(2, 1'b1);

        // Single FU2 result with known fields.
        rand_fields(2);
        fu_out_inst_id[2]       = 6'd5;
        fu_out_prn[2][0]        = 6'd12;
        fu_out_data[2][0]       = 64'hAB;
        fu_out_data_valid[2][0] = 1'b1;
        fu_out_valid            = 4'b0100;
        wb_ready                = 1'b1;
        step();
        fu_out_valid = '0;
        check("t1_valid", 64'(wb_valid), 64'd1);
        check("t1_idx", 64'(wb_fu_idx), 64'd2);
        check("t1_inst", 64'(wb_inst_id), 64'd5);
        check("t1_data0", wb_data[0], 64'hAB);
        step();
        check("t1_idle_valid", 64'(wb_valid), 64'd0);
        check("t1_idle_data0", wb_data[0], 64'd0);
        idle(2, 1'b1);

        // All four FUs at once drain in index order from rr_ptr=0.
        do_reset();
        drive(4'b1111, 1'b1);
        for (int i = 0; i < N; i++) begin
            check("t2_seq_idx", 64'(wb_fu_idx), 64'(i));
            step();
        end
        check("t2_done", 64'(wb_valid), 64'd0);

        // After an FU1 grant, FU3 wins over FU0.
        drive(4'b0010, 1'b1);
        step();
        drive(4'b1001, 1'b0);
        check("t3_first", 64'(wb_fu_idx), 64'd3);
        idle(1, 1'b1);
        check("t3_second", 64'(wb_fu_idx), 64'd0);
        idle(2, 1'b1);

        // Fill FU1, overflow on the third push, then drain.
        drive(4'b0010, 1'b0);
        check("t4_hold", 64'(fu_hold[1]), 64'd1);
        drive(4'b0010, 1'b0);
        drive(4'b0010, 1'b0);
        check("t4_ovf", 64'(overflow_err), 64'd1);
        idle(4, 1'b1);

        // Full queue: same-cycle pop and push, no overflow.
        do_reset();
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b0);
        drive(4'b0100, 1'b1);
        check("t5_no_ovf", 64'(overflow_err), 64'd0);
        check("t5_hold", 64'(fu_hold[2]), 64'd1);
        idle(4, 1'b1);

        // Asynchronous reset with results queued and a sticky overflow.
        drive(4'b0001, 1'b0);
        drive(4'b0001, 1'b0);
        drive(4'b1011, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("t6_valid", 64'(wb_valid), 64'd0);
        check("t6_hold", 64'(fu_hold), 64'd0);
        check("t6_ovf", 64'(overflow_err), 64'd0);
        step();
        rst = 1'b1;
        idle(2, 1'b1);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            if (c % 500 == 250) do_reset();
            drive(N'($urandom & $urandom), ($urandom % 4) != 0);
        end
        idle(12, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
